// File: rtl/fpu_result_buffer_if.sv
// Bundle of the issue, FPU-result and core-result handshakes around the FPU result buffer.
// The buffer takes the slave view; the environment driving it takes the master view.
interface fpu_result_buffer_if #(
    parameter int DEPTH      = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  issue_fire_i;
    logic [ID_WIDTH-1:0]   issue_id_i;
    logic [4:0]            issue_rd_i;
    logic                  issue_stall_o;
    logic                  fpu_valid_i;
    logic                  fpu_ready_o;
    logic [DATA_WIDTH-1:0] fpu_data_i;
    logic [4:0]            fpu_status_i;
    logic                  result_valid_o;
    logic                  result_ready_i;
    logic [ID_WIDTH-1:0]   result_id_o;
    logic [4:0]            result_rd_o;
    logic [DATA_WIDTH-1:0] result_data_o;
    logic                  result_we_o;
    logic [4:0]            result_fflags_o;
    logic                  flush_i;
    logic [CW-1:0]         count_o;
    logic                  err_o;

    modport slave (
        input  issue_fire_i, issue_id_i, issue_rd_i,
        input  fpu_valid_i, fpu_data_i, fpu_status_i,
        input  result_ready_i, flush_i,
        output issue_stall_o, fpu_ready_o,
        output result_valid_o, result_id_o, result_rd_o, result_data_o,
        output result_we_o, result_fflags_o, count_o, err_o
    );

    modport master (
        output issue_fire_i, issue_id_i, issue_rd_i,
        output fpu_valid_i, fpu_data_i, fpu_status_i,
        output result_ready_i, flush_i,
        input  issue_stall_o, fpu_ready_o,
        input  result_valid_o, result_id_o, result_rd_o, result_data_o,
        input  result_we_o, result_fflags_o, count_o, err_o
    );
endinterface

// File: rtl/fpu_result_buffer.sv
// In-order result buffer: ids are allocated at issue, FPU results fill them in issue order,
// and completed entries drain to the core from the head with one cycle of latency.
module fpu_result_buffer #(
    parameter int DEPTH      = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    fpu_result_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] tail_reg, tail_next;
    logic [PW-1:0] fill_reg, fill_next;
    logic [PW-1:0] head_reg, head_next;
    logic [DEPTH-1:0] done_reg, done_next;
    logic err_reg, err_next;

    logic [ID_WIDTH-1:0]   id_mem     [DEPTH];
    logic [4:0]            rd_mem     [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem   [DEPTH];
    logic [4:0]            fflags_mem [DEPTH];

    logic [AW-1:0] tail_idx, fill_idx, head_idx;
    logic [PW-1:0] count;
    logic stall, fpu_ready, result_valid;
    logic alloc, fill_en, drain;
    logic [DEPTH-1:0] alloc_hit, fill_hit;

    assign tail_idx = tail_reg[AW-1:0];
    assign fill_idx = fill_reg[AW-1:0];
    assign head_idx = head_reg[AW-1:0];

    // Wrap bit in the MSB makes tail - head the occupancy, DEPTH meaning full.
    assign count        = tail_reg - head_reg;
    assign stall        = (count == PW'(DEPTH));
    assign fpu_ready    = (fill_reg != tail_reg);
    assign result_valid = (head_reg != fill_reg) && done_reg[head_idx];

    assign alloc   = bus.issue_fire_i && !stall;
    assign fill_en = bus.fpu_valid_i && fpu_ready;
    assign drain   = result_valid && bus.result_ready_i;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_hit
            assign alloc_hit[gi] = alloc   && (tail_idx == AW'(gi));
            assign fill_hit[gi]  = fill_en && (fill_idx == AW'(gi));
        end
    endgenerate

    always_comb begin
        tail_next = tail_reg;
        fill_next = fill_reg;
        head_next = head_reg;
        done_next = (done_reg & ~alloc_hit) | fill_hit;
        err_next  = err_reg
                  | (bus.issue_fire_i && stall)
                  | (bus.fpu_valid_i && !fpu_ready);
        if (alloc)   tail_next = tail_reg + PW'(1);
        if (fill_en) fill_next = fill_reg + PW'(1);
        if (drain)   head_next = head_reg + PW'(1);
        if (bus.flush_i) begin
            tail_next = '0;
            fill_next = '0;
            head_next = '0;
            done_next = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tail_reg <= '0;
            fill_reg <= '0;
            head_reg <= '0;
            done_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            tail_reg <= tail_next;
            fill_reg <= fill_next;
            head_reg <= head_next;
            done_reg <= done_next;
            err_reg  <= err_next;
        end
    end

    // Payload storage needs no reset; validity lives entirely in the pointers and done bits.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            id_mem[tail_idx] <= bus.issue_id_i;
            rd_mem[tail_idx] <= bus.issue_rd_i;
        end
        if (fill_en) begin
            data_mem[fill_idx]   <= bus.fpu_data_i;
            fflags_mem[fill_idx] <= bus.fpu_status_i;
        end
    end

    assign bus.issue_stall_o   = stall;
    assign bus.fpu_ready_o     = fpu_ready;
    assign bus.result_valid_o  = result_valid;
    assign bus.result_we_o     = result_valid;
    assign bus.result_id_o     = id_mem[head_idx];
    assign bus.result_rd_o     = rd_mem[head_idx];
    assign bus.result_data_o   = data_mem[head_idx];
    assign bus.result_fflags_o = fflags_mem[head_idx];
    assign bus.count_o         = count;
    assign bus.err_o           = err_reg;
endmodule

// File: tb/tb_fpu_result_buffer.sv
// Directed bench for fpu_result_buffer with DEPTH=4: single op, full/stall, back-pressure,
// simultaneous alloc/fill/drain, flush, reset-as-flush and pointer wrap.
module tb_fpu_result_buffer;
    logic clk = 1'b0;
    logic rst_n;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fpu_result_buffer_if #(.DEPTH(4), .ID_WIDTH(4), .DATA_WIDTH(32)) bus ();

    fpu_result_buffer #(.DEPTH(4), .ID_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_fire_i   = 1'b0;
        bus.issue_id_i     = '0;
        bus.issue_rd_i     = '0;
        bus.fpu_valid_i    = 1'b0;
        bus.fpu_data_i     = '0;
        bus.fpu_status_i   = '0;
        bus.result_ready_i = 1'b0;
        bus.flush_i        = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [3:0] id, input logic [4:0] rd);
        bus.issue_fire_i = 1'b1;
        bus.issue_id_i   = id;
        bus.issue_rd_i   = rd;
        step();
        bus.issue_fire_i = 1'b0;
    endtask

    task automatic fpu_ret(input logic [31:0] data, input logic [4:0] st);
        bus.fpu_valid_i  = 1'b1;
        bus.fpu_data_i   = data;
        bus.fpu_status_i = st;
        step();
        bus.fpu_valid_i  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();
        $display("reset state");
        check("rst_stall",  64'(bus.issue_stall_o),  64'd0);
        check("rst_fready", 64'(bus.fpu_ready_o),    64'd0);
        check("rst_valid",  64'(bus.result_valid_o), 64'd0);
        check("rst_we",     64'(bus.result_we_o),    64'd0);
        check("rst_count",  64'(bus.count_o),        64'd0);
        check("rst_err",    64'(bus.err_o),          64'd0);

        // single operation, result one cycle after the FPU handshake
        issue(4'd3, 5'd5);
        $display("single: issued id=3 rd=5");
        check("single_count1", 64'(bus.count_o),        64'd1);
        check("single_fready", 64'(bus.fpu_ready_o),    64'd1);
        check("single_novld",  64'(bus.result_valid_o), 64'd0);
        step();
        fpu_ret(32'h4040_0000, 5'b00001);
        $display("single: fpu returned 0x40400000");
        check("single_valid",  64'(bus.result_valid_o),  64'd1);
        check("single_id",     64'(bus.result_id_o),     64'd3);
        check("single_rd",     64'(bus.result_rd_o),     64'd5);
        check("single_data",   64'(bus.result_data_o),   64'h4040_0000);
        check("single_we",     64'(bus.result_we_o),     64'd1);
        check("single_fflags", 64'(bus.result_fflags_o), 64'd1);
        check("single_nordy",  64'(bus.fpu_ready_o),     64'd0);
        bus.result_ready_i = 1'b1;
        step();
        bus.result_ready_i = 1'b0;
        $display("single: accepted");
        check("single_count0", 64'(bus.count_o),        64'd0);
        check("single_done",   64'(bus.result_valid_o), 64'd0);

        // fill to full, fifth issue ignored
        for (int i = 0; i < 4; i++) issue(4'(i), 5'(10 + i));
        $display("full: 4 issues");
        check("full_stall", 64'(bus.issue_stall_o), 64'd1);
        check("full_count", 64'(bus.count_o),       64'd4);
        check("full_noerr", 64'(bus.err_o),         64'd0);
        issue(4'd9, 5'd31);
        $display("full: 5th issue while stalled");
        check("over_count", 64'(bus.count_o), 64'd4);
        check("over_err",   64'(bus.err_o),   64'd1);

        // simultaneous drain + fill at full, then alloc + drain
        fpu_ret(32'h100, 5'd0);
        check("sim_head_id", 64'(bus.result_id_o), 64'd0);
        check("sim_count4",  64'(bus.count_o),     64'd4);
        bus.result_ready_i = 1'b1;
        fpu_ret(32'h101, 5'd2);
        bus.result_ready_i = 1'b0;
        $display("sim: drain+fill at count 4");
        check("sim_count3", 64'(bus.count_o),        64'd3);
        check("sim_stall0", 64'(bus.issue_stall_o),  64'd0);
        check("sim_id1",    64'(bus.result_id_o),    64'd1);
        check("sim_data1",  64'(bus.result_data_o),  64'h101);
        check("sim_rd1",    64'(bus.result_rd_o),    64'd11);
        bus.result_ready_i = 1'b1;
        issue(4'd4, 5'd14);
        bus.result_ready_i = 1'b0;
        $display("sim: alloc+drain");
        check("sim_count_same", 64'(bus.count_o),        64'd3);
        check("sim_head_pend",  64'(bus.result_valid_o), 64'd0);
        check("sim_fready",     64'(bus.fpu_ready_o),    64'd1);

        // reset mid-operation drops everything
        do_reset();
        $display("mid-op reset");
        check("mrst_count", 64'(bus.count_o),        64'd0);
        check("mrst_valid", 64'(bus.result_valid_o), 64'd0);
        check("mrst_err",   64'(bus.err_o),          64'd0);

        // flush with two pending and an FPU result in the same cycle
        issue(4'd5, 5'd1);
        issue(4'd6, 5'd2);
        bus.flush_i = 1'b1;
        fpu_ret(32'hdead, 5'd0);
        bus.flush_i = 1'b0;
        $display("flush with 2 pending");
        check("flush_count",  64'(bus.count_o),        64'd0);
        check("flush_valid",  64'(bus.result_valid_o), 64'd0);
        check("flush_fready", 64'(bus.fpu_ready_o),    64'd0);
        check("flush_noerr",  64'(bus.err_o),          64'd0);
        fpu_ret(32'hbeef, 5'd0);
        $display("stray fpu_valid after flush");
        check("stray_err",   64'(bus.err_o),          64'd1);
        check("stray_valid", 64'(bus.result_valid_o), 64'd0);

        // back-pressure: three done results held, then drained in order
        do_reset();
        for (int i = 1; i <= 3; i++) issue(4'(i), 5'(i));
        for (int i = 1; i <= 3; i++) fpu_ret(32'(32'hA0 + i), 5'(i));
        for (int c = 0; c < 5; c++) begin
            $display("backpressure: hold cycle %0d", c);
            check("bp_valid", 64'(bus.result_valid_o),  64'd1);
            check("bp_id",    64'(bus.result_id_o),     64'd1);
            check("bp_data",  64'(bus.result_data_o),   64'hA1);
            check("bp_ffl",   64'(bus.result_fflags_o), 64'd1);
            step();
        end
        bus.result_ready_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            $display("backpressure: drain expect id %0d", i);
            check("bp_drain_vld",  64'(bus.result_valid_o), 64'd1);
            check("bp_drain_id",   64'(bus.result_id_o),    64'(i));
            check("bp_drain_data", 64'(bus.result_data_o),  64'(32'hA0 + i));
            step();
        end
        bus.result_ready_i = 1'b0;
        check("bp_empty", 64'(bus.result_valid_o), 64'd0);
        check("bp_count", 64'(bus.count_o),        64'd0);

        // wrap: ten issue/result/drain sequences through DEPTH=4
        do_reset();
        for (int k = 0; k < 10; k++) begin
            issue(4'(k + 7), 5'(k + 20));
            fpu_ret(32'(32'h1000 + k), 5'(k));
            $display("wrap: seq %0d expect id %0d", k, (k + 7) % 16);
            check("wrap_valid", 64'(bus.result_valid_o), 64'd1);
            check("wrap_id",    64'(bus.result_id_o),    64'((k + 7) % 16));
            check("wrap_rd",    64'(bus.result_rd_o),    64'(k + 20));
            check("wrap_data",  64'(bus.result_data_o),  64'(32'h1000 + k));
            bus.result_ready_i = 1'b1;
            step();
            bus.result_ready_i = 1'b0;
            check("wrap_count", 64'(bus.count_o), 64'd0);
        end
        check("wrap_err", 64'(bus.err_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fpu_result_buffer.md
FPU_RESULT_BUFFER -- requirements
Module: fpu_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of in-flight entries (power of two, at least 2).
REQ-002 SHALL have parameter ID_WIDTH, default 4, width of the CV-X-IF instruction id.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, width of the FPU result.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port issue_fire_i  input  1  an issue handshake to the FPU completes this cycle.
REQ-007 SHALL have port issue_id_i  input  ID_WIDTH  id of the issued instruction.
REQ-008 SHALL have port issue_rd_i  input  5  destination register, instr[11:7].
REQ-009 SHALL have port issue_stall_o  output  1  buffer full; upstream SHALL gate issue ready with it.
REQ-010 SHALL have port fpu_valid_i  input  1  FPU result valid.
REQ-011 SHALL have port fpu_ready_o  output  1  buffer accepts an FPU result.
REQ-012 SHALL have port fpu_data_i  input  DATA_WIDTH  FPU result data.
REQ-013 SHALL have port fpu_status_i  input  5  FPU fflags {NV,DZ,OF,UF,NX}.
REQ-014 SHALL have port result_valid_o  output  1  CV-X-IF result valid.
REQ-015 SHALL have port result_ready_i  input  1  core accepts result.
REQ-016 SHALL have port result_id_o  output  ID_WIDTH  id of head result.
REQ-017 SHALL have port result_rd_o  output  5  rd of head result.
REQ-018 SHALL have port result_data_o  output  DATA_WIDTH  head result data.
REQ-019 SHALL have port result_we_o  output  1  register write enable; equals result_valid_o.
REQ-020 SHALL have port result_fflags_o  output  5  head result fflags.
REQ-021 SHALL have port flush_i  input  1  discard all entries.
REQ-022 SHALL have port count_o  output  $clog2(DEPTH)+1  number of allocated entries.
REQ-023 SHALL have port err_o  output  1  sticky protocol error flag.

Function
REQ-024 SHALL keep a circular table of DEPTH entries {id, rd, data, fflags, done} with three pointers of $clog2(DEPTH)+1 bits (MSB = wrap bit): tail (alloc), fill, head (drain).
REQ-025 SHALL allocate at tail on issue_fire_i && !issue_stall_o: store id, rd, clear done, tail+1.
REQ-026 SHALL drive fpu_ready_o = (fill != tail), i.e. at least one allocated unfilled entry.
REQ-027 SHALL, on fpu_valid_i && fpu_ready_o, write data and fflags into entry[fill], set done, fill+1; results bind to ids in issue order.
REQ-028 SHALL drive result_valid_o = (head != fill) with entry[head] fields from registered state; latency FPU handshake -> result_valid_o is exactly 1 cycle; no combinational bypass.
REQ-029 SHALL hold all result_* outputs stable while result_valid_o && !result_ready_i.
REQ-030 SHALL, on result_valid_o && result_ready_i, retire entry[head], head+1.
REQ-031 SHALL drive issue_stall_o = (count_o == DEPTH), count_o = tail - head.
REQ-032 SHALL allow alloc, fill and drain in the same cycle; count changes by (alloc - drain).
REQ-033 SHALL ignore issue_fire_i while issue_stall_o is 1 and set err_o.
REQ-034 SHALL set err_o when fpu_valid_i is 1 while no entry is allocated-unfilled (fill == tail); data is dropped.
REQ-035 SHALL wrap pointers modulo 2*DEPTH; full = index bits equal and wrap bits differ.
REQ-036 SHALL, on flush_i, set head = fill = tail = 0 next cycle and discard all entries; flush_i overrides alloc, fill and drain in the same cycle; err_o is unaffected.

Reset
REQ-037 SHALL, while rst_ni is 0 at a rising edge, clear pointers, done bits and err_o; after reset issue_stall_o=0, fpu_ready_o=0, result_valid_o=0, result_we_o=0, count_o=0, err_o=0; data/id/rd storage needs no reset.
REQ-038 SHALL treat reset asserted mid-operation like flush: all in-flight entries lost, no result emitted.

Verification
REQ-039 Single op: issue id=3 rd=5; FPU returns 0x40400000 two cycles later -> next cycle result_valid_o=1, id=3, rd=5, data=0x40400000, we=1; count 1->0 on accept.
REQ-040 Fill to full: 4 issues, no FPU results -> issue_stall_o=1, count_o=4; 5th issue_fire_i -> ignored, err_o=1.
REQ-041 Back-pressure: 3 results done, result_ready_i=0 for 5 cycles -> outputs stable; then ready=1 -> ids drained in issue order, one per cycle.
REQ-042 Simultaneous: count=4, same cycle drain + FPU fill -> count_o=3, issue_stall_o=0 next cycle; then simultaneous alloc + drain -> count unchanged.
REQ-043 Flush with 2 pending and fpu_valid_i=1 same cycle -> next cycle count_o=0, result_valid_o=0, fpu_ready_o=0; stray fpu_valid_i afterwards -> err_o=1.
REQ-044 Wrap: 10 back-to-back issue/result/drain sequences with DEPTH=4 -> every id returned exactly once, in order, err_o=0.
